// File: rtl/block_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | block_buf_pkg : shared helpers for the block reorder buffer        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package block_buf_pkg;

  // Modulo-NBUF pointer advance that also works for non-power-of-2 ring sizes.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned nbuf);
    return (ptr + 1 >= nbuf) ? 0 : ptr + 1;
  endfunction

  // Source coordinates for output element j of index idx in row or column mode.
  function automatic int unsigned src_row(input int unsigned idx, input int unsigned j,
                                          input logic mode);
    return mode ? j : idx;
  endfunction

  function automatic int unsigned src_col(input int unsigned idx, input int unsigned j,
                                          input logic mode);
    return mode ? idx : j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_slot_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | block_slot_mem : NBUF x N row store with per-slot mode/sof bits    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module block_slot_mem
  import block_buf_pkg::*;
#(
  parameter int W_IO = 16,
  parameter int N    = 8,
  parameter int NBUF = 2
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(NBUF)-1:0] wr_slot,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [N*W_IO-1:0]       wr_data,
  input  logic                    wr_mode,
  input  logic                    wr_sof,
  input  logic [$clog2(NBUF)-1:0] rd_slot,
  input  logic [$clog2(N)-1:0]    rd_idx,
  output logic [N*W_IO-1:0]       rd_data,
  output logic                    rd_sof
);

  typedef logic [N-1:0][W_IO-1:0] row_t;

  row_t r_mem  [NBUF][N];
  logic r_mode [NBUF];
  logic r_sof  [NBUF];
  row_t w_sel;
  logic w_mode;

  // Side-band bits belong to the block and are captured with its first row.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_slot][wr_row] <= row_t'(wr_data);
      if (wr_row == '0) begin
        r_mode[wr_slot] <= wr_mode;
        r_sof[wr_slot]  <= wr_sof;
      end
    end
  end

  assign w_mode = r_mode[rd_slot];

  for (genvar j = 0; j < N; j++) begin : g_elem
    assign w_sel[j] = r_mem[rd_slot][src_row(32'(rd_idx), j, w_mode)]
                           [src_col(32'(rd_idx), j, w_mode)];
  end

  assign rd_data = w_sel;
  assign rd_sof  = r_sof[rd_slot];

endmodule
`default_nettype wire

// File: rtl/block_reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | block_reorder_buffer : NBUF-slot NxN block buffer, row/transpose   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module block_reorder_buffer
  import block_buf_pkg::*;
#(
  parameter int W_IO     = 16,
  parameter int N        = 8,
  parameter int NBUF     = 2,
  parameter bit DEF_TRPS = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*W_IO-1:0]         in_data,
  input  logic                      in_sob,
  input  logic                      in_eob,
  input  logic                      in_sof,
  input  logic                      in_trps_en,
  input  logic                      in_trps,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*W_IO-1:0]         out_data,
  output logic                      out_sob,
  output logic                      out_eob,
  output logic                      out_sof,
  output logic [$clog2(NBUF+1)-1:0] level,
  output logic                      err
);

  localparam int c_pw = $clog2(NBUF);
  localparam int c_rw = $clog2(N);
  localparam int c_lw = $clog2(NBUF+1);

  logic [c_pw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_rw-1:0] r_in_row, r_out_row;
  logic [c_lw-1:0] r_level;
  logic            r_err;

  logic w_acc, w_pop, w_in_last, w_out_last, w_commit, w_release, w_frame_bad;
  logic w_rd_sof;

  assign in_ready    = (r_level < c_lw'(NBUF));
  assign out_valid   = (r_level != '0);
  assign w_acc       = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_in_last   = (r_in_row == c_rw'(N-1));
  assign w_out_last  = (r_out_row == c_rw'(N-1));
  assign w_commit    = w_acc & w_in_last;
  assign w_release   = w_pop & w_out_last;
  assign w_frame_bad = (in_sob != (r_in_row == '0)) | (in_eob != w_in_last);

  // Block boundaries come from the row counter alone; sob/eob only feed err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_in_row  <= '0;
      r_out_row <= '0;
      r_level   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_in_row <= w_in_last ? '0 : r_in_row + c_rw'(1);
        if (w_frame_bad) r_err <= 1'b1;
      end
      if (w_commit) r_wr_ptr <= c_pw'(ptr_inc(32'(r_wr_ptr), NBUF));
      if (w_pop) r_out_row <= w_out_last ? '0 : r_out_row + c_rw'(1);
      if (w_release) r_rd_ptr <= c_pw'(ptr_inc(32'(r_rd_ptr), NBUF));
      if (w_commit && !w_release) r_level <= r_level + c_lw'(1);
      else if (!w_commit && w_release) r_level <= r_level - c_lw'(1);
    end
  end

  block_slot_mem #(
    .W_IO (W_IO),
    .N    (N),
    .NBUF (NBUF)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_acc),
    .wr_slot (r_wr_ptr),
    .wr_row  (r_in_row),
    .wr_data (in_data),
    .wr_mode (in_trps_en ? in_trps : DEF_TRPS),
    .wr_sof  (in_sof),
    .rd_slot (r_rd_ptr),
    .rd_idx  (r_out_row),
    .rd_data (out_data),
    .rd_sof  (w_rd_sof)
  );

  assign out_sob = out_valid & (r_out_row == '0);
  assign out_eob = out_valid & w_out_last;
  assign out_sof = out_valid & w_rd_sof;
  assign level   = r_level;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_block_reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_block_reorder_buffer : directed self-checking bench             |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_block_reorder_buffer;

  localparam int W_IO = 16;
  localparam int N    = 8;
  localparam int NBUF = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N*W_IO-1:0] in_data;
  logic              in_sob, in_eob, in_sof, in_trps_en, in_trps;
  logic              out_valid;
  logic              out_ready;
  logic [N*W_IO-1:0] out_data;
  logic              out_sob, out_eob, out_sof;
  logic [1:0]        level;
  logic              err;

  int errors = 0;
  int checks = 0;

  block_reorder_buffer #(
    .W_IO     (W_IO),
    .N        (N),
    .NBUF     (NBUF),
    .DEF_TRPS (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sob     (in_sob),
    .in_eob     (in_eob),
    .in_sof     (in_sof),
    .in_trps_en (in_trps_en),
    .in_trps    (in_trps),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sob    (out_sob),
    .out_eob    (out_eob),
    .out_sof    (out_sof),
    .level      (level),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element e of row r in block b is 100*b + 8*r + e; transposed swaps r and e.
  function automatic logic [N*W_IO-1:0] exp_row(input int b, input int r, input bit t);
    logic [N*W_IO-1:0] v;
    for (int e = 0; e < N; e++)
      v[e*W_IO +: W_IO] = W_IO'(t ? (100*b + 8*e + r) : (100*b + 8*r + e));
    return v;
  endfunction

  task automatic drive_row(input int b, input int r, input bit v, input bit sof,
                           input bit ten, input bit trps);
    in_valid   = v;
    in_sob     = (r == 0);
    in_eob     = (r == N-1);
    in_sof     = sof;
    in_trps_en = ten;
    in_trps    = trps;
    for (int e = 0; e < N; e++) in_data[e*W_IO +: W_IO] = W_IO'(100*b + 8*r + e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_row(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    repeat (2) step();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    rst_n = 1'b1;
    step();
    checks++; if (level !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release level=%0d out_valid=%b exp 0/0", level, out_valid);
    end
  endtask

  // Three blocks at full rate; the commit of block k+1 coincides with the pop of block k.
  task automatic test_identity();
    int k;
    out_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      drive_row(c / N, c % N, c < 3*N, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== (c >= N && c < 4*N)) begin
        errors++; $display("FAIL id_out_valid c=%0d got %b", c, out_valid);
      end
      checks++; if (level !== ((c >= N && c < 4*N) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL id_commit_pop_level c=%0d got %0d", c, level);
      end
      if (c < 3*N) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL id_in_ready c=%0d got %b exp 1", c, in_ready); end
      end
      if (c >= N && c < 4*N) begin
        k = c - N;
        checks++; if (out_data !== exp_row(k / N, k % N, 1'b0)) begin
          errors++; $display("FAIL id_data c=%0d got %h exp %h", c, out_data, exp_row(k / N, k % N, 1'b0));
        end
        checks++; if (out_sob !== (k % N == 0) || out_eob !== (k % N == N-1)) begin
          errors++; $display("FAIL id_sob_eob c=%0d got %b%b", c, out_sob, out_eob);
        end
      end
      step();
    end
  endtask

  // Block 0 is transposed via in_trps, block 1 falls back to DEF_TRPS=0.
  task automatic test_transpose();
    int k;
    bit t;
    out_ready = 1'b1;
    for (int c = 0; c < 2*N + N + 2; c++) begin
      drive_row(c / N, c % N, c < 2*N, c < N, c < N, c < N);
      if (c >= N && c < 3*N) begin
        k = c - N;
        t = (k / N == 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tr_out_valid c=%0d got %b", c, out_valid); end
        checks++; if (out_data !== exp_row(k / N, k % N, t)) begin
          errors++; $display("FAIL tr_data c=%0d got %h exp %h", c, out_data, exp_row(k / N, k % N, t));
        end
        checks++; if (out_sof !== t) begin errors++; $display("FAIL tr_sof c=%0d got %b exp %b", c, out_sof, t); end
      end
      step();
    end
  endtask

  // Four blocks into three slots with output stalled, then drain.
  task automatic test_backpressure();
    int ii, oi, c;
    bit acc, pop;
    ii = 0; oi = 0; c = 0;
    out_ready = 1'b0;
    while (c < 200 && oi < 4*N) begin
      drive_row(20 + ii / N, ii % N, ii < 4*N, 1'b0, 1'b0, 1'b0);
      if (c == 30) begin
        checks++; if (level !== 2'd3) begin errors++; $display("FAIL bp_full_level got %0d exp 3", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== exp_row(20, 0, 1'b0) || out_sob !== 1'b1) begin
          errors++; $display("FAIL bp_stall_hold got %h sob=%b exp %h sob=1", out_data, out_sob, exp_row(20, 0, 1'b0));
        end
      end
      if (c == 35) out_ready = 1'b1;
      if (out_valid && out_ready) begin
        checks++; if (out_data !== exp_row(20 + oi / N, oi % N, 1'b0)) begin
          errors++; $display("FAIL bp_drain_data oi=%0d got %h exp %h", oi, out_data, exp_row(20 + oi / N, oi % N, 1'b0));
        end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      step();
      if (acc) ii++;
      if (pop) oi++;
      c++;
    end
    in_valid = 1'b0;
    checks++; if (oi != 4*N) begin errors++; $display("FAIL bp_timeout drained %0d rows exp %0d", oi, 4*N); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL bp_end_level got %0d exp 0", level); end
  endtask

  task automatic test_framing();
    out_ready = 1'b0;
    for (int r = 0; r < N; r++) begin
      drive_row(5, r, 1'b1, 1'b0, 1'b0, 1'b0);
      in_eob = (r == 5) || (r == N-1);
      checks++; if (err !== (r > 5)) begin errors++; $display("FAIL fr_err r=%0d got %b exp %b", r, err, r > 5); end
      step();
    end
    in_valid = 1'b0;
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL fr_commit_level got %0d exp 1", level); end
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      checks++; if (out_data !== exp_row(5, r, 1'b0)) begin
        errors++; $display("FAIL fr_data r=%0d got %h exp %h", r, out_data, exp_row(5, r, 1'b0));
      end
      step();
    end
    checks++; if (err !== 1'b1 || level !== 2'd0) begin
      errors++; $display("FAIL fr_sticky err=%b level=%0d exp 1/0", err, level);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      drive_row(6 + c / N, c % N, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL rm_pre_level got %0d exp 1", level); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL rm_reset level=%0d out_valid=%b in_ready=%b err=%b exp 0/0/1/0", level, out_valid, in_ready, err);
    end
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 2*N + 1; c++) begin
      drive_row(8, c % N, c < N, 1'b1, 1'b0, 1'b0);
      checks++; if (out_valid !== (c >= N && c < 2*N)) begin
        errors++; $display("FAIL rm_out_valid c=%0d got %b", c, out_valid);
      end
      if (c >= N && c < 2*N) begin
        checks++; if (out_data !== exp_row(8, c - N, 1'b0) || out_sof !== 1'b1) begin
          errors++; $display("FAIL rm_data c=%0d got %h sof=%b exp %h sof=1", c, out_data, out_sof, exp_row(8, c - N, 1'b0));
        end
        checks++; if (out_sob !== (c == N)) begin errors++; $display("FAIL rm_sob c=%0d got %b", c, out_sob); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_transpose();
    test_backpressure();
    test_framing();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
